// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution tile scheduler.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int unsigned FP32_SIGN_BIT = 31;

  // Valid-convolution output extent for one dimension.
  function automatic int unsigned OUTPUT_SIZE(input int unsigned is, input int unsigned ks);
    return is - ks + 1;
  endfunction

  // Bit width for an index range of v values, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO holding the output address of every job in flight.
module tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_n;

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count_n = count + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/conv_tile_scheduler.sv
// Walks every (row, col, filter) output position of a conv layer through one
// shared pipelined filter engine and writes the in-order results to the output buffer.
module conv_tile_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_WIDTH   = 3,
  parameter int unsigned KERNEL_HEIGHT  = 3,
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned INPUT_HEIGHT   = 8,
  parameter int unsigned FILTERS_NUMBER = 4,
  parameter int unsigned VALUE_BITS     = 32,
  parameter int unsigned MAX_INFLIGHT   = 8,
  localparam int unsigned OUT_H = OUTPUT_SIZE(INPUT_HEIGHT, KERNEL_HEIGHT),
  localparam int unsigned OUT_W = OUTPUT_SIZE(INPUT_WIDTH, KERNEL_WIDTH),
  localparam int unsigned TOTAL = OUT_H * OUT_W * FILTERS_NUMBER,
  localparam int unsigned AW    = clog2_min1(TOTAL),
  localparam int unsigned RW    = clog2_min1(OUT_H),
  localparam int unsigned CLW   = clog2_min1(OUT_W),
  localparam int unsigned FW    = clog2_min1(FILTERS_NUMBER)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [RW-1:0]         issue_row,
  output logic [CLW-1:0]        issue_col,
  output logic [FW-1:0]         issue_filter,
  input  logic                  res_valid,
  input  logic [VALUE_BITS-1:0] res_data,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [VALUE_BITS-1:0] wr_data
);

  localparam int unsigned IW       = $clog2(MAX_INFLIGHT) + 1;
  localparam int unsigned SIGN_BIT = (VALUE_BITS == 32) ? FP32_SIGN_BIT : VALUE_BITS - 1;

  conv_state_t   state;
  conv_state_t   state_n;
  logic          issue_valid_n;
  logic          busy_n;
  logic          done_n;
  logic          relu_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] tag;
  logic [IW-1:0] inflight;
  logic [IW-1:0] inflight_n;
  logic          full;
  logic          empty;
  logic          hs;
  logic          res_ok;
  logic          last_f;
  logic          last_w;
  logic          last_pos;
  logic          accept;

  tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (AW)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hs),
    .push_data (addr_q),
    .pop       (res_valid),
    .pop_data  (tag),
    .count     (inflight),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    accept     = (state == IDLE) && start;
    hs         = issue_valid && issue_ready && !full;
    res_ok     = res_valid && !empty;
    last_f     = (issue_filter == FW'(FILTERS_NUMBER - 1));
    last_w     = (issue_col == CLW'(OUT_W - 1));
    last_pos   = last_f && last_w && (issue_row == RW'(OUT_H - 1));
    inflight_n = inflight + IW'(hs) - IW'(res_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state plus next values of the registered control outputs.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (hs && last_pos) state_n = DRAIN;
      DRAIN:   if (inflight == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    issue_valid_n = (state_n == RUN) && (inflight_n < IW'(MAX_INFLIGHT));
    busy_n        = (state_n == RUN) || (state_n == DRAIN);
    done_n        = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      issue_valid <= issue_valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Position counters: filter fastest, then column, then row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_row    <= '0;
      issue_col    <= '0;
      issue_filter <= '0;
      addr_q       <= '0;
      relu_q       <= 1'b0;
    end else if (accept) begin
      issue_row    <= '0;
      issue_col    <= '0;
      issue_filter <= '0;
      addr_q       <= '0;
      relu_q       <= relu_en;
    end else if (hs) begin
      addr_q       <= addr_q + AW'(1);
      issue_filter <= last_f ? '0 : issue_filter + FW'(1);
      if (last_f) begin
        issue_col <= last_w ? '0 : issue_col + CLW'(1);
        if (last_w) issue_row <= (issue_row == RW'(OUT_H - 1)) ? '0 : issue_row + RW'(1);
      end
    end
  end

  // Result write-back; a result with nothing in flight is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (accept) err <= 1'b0;
      if (res_valid && empty) err <= 1'b1;
      wr_en <= res_ok;
      if (res_ok) begin
        wr_addr <= tag;
        wr_data <= (relu_q && res_data[SIGN_BIT]) ? '0 : res_data;
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler with a fixed-latency in-order engine model.
module tb_conv_tile_scheduler;

  localparam int TOTAL = 144;
  localparam int OUT_W = 6;
  localparam int FNUM  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        relu_en;
  logic        busy;
  logic        done;
  logic        err;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_row;
  logic [2:0]  issue_col;
  logic [1:0]  issue_filter;
  logic        res_valid;
  logic [31:0] res_data;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  conv_tile_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .relu_en      (relu_en),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_row    (issue_row),
    .issue_col    (issue_col),
    .issue_filter (issue_filter),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  typedef struct { int due; int idx; } job_t;
  typedef struct { int addr; logic [31:0] data; } wr_t;

  job_t        pend[$];
  wr_t         expq[$];
  int          vec_cnt = 0;
  int          miss_cnt = 0;
  int          cyc = 0;
  int          lat = 4;
  int          issue_idx = 0;
  int          wr_count = 0;
  int          last_wr_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done_base = 0;
  bit          hold_res = 1'b0;
  bit          spur_req = 1'b0;
  bit          relu_cur = 1'b0;
  logic [31:0] first_wr [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] job_data(input int idx);
    if (relu_cur) begin
      case (idx % 4)
        0:       return 32'hC000_0000;
        1:       return 32'h3F80_0000;
        2:       return 32'h8000_0000;
        default: return 32'h4120_0000;
      endcase
    end
    return 32'h4000_0000 | 32'(idx);
  endfunction

  // Engine model and write monitor, both on the falling edge.
  initial begin
    job_t        p;
    wr_t         e;
    logic [31:0] d;
    int          flat;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
        expq.delete();
        res_valid = 1'b0;
        continue;
      end
      if (wr_en) begin
        if (expq.size() == 0) begin
          chk("wr_unexpected", 32'(wr_en), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", wr_data, e.data);
          wr_count++;
          last_wr_cyc = cyc;
          if (wr_count <= 3) first_wr[wr_count-1] = wr_data;
        end
      end else if (expq.size() != 0) begin
        chk("wr_missing", 32'(wr_en), 32'd1);
        void'(expq.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (issue_valid && issue_ready) begin
        flat = int'(issue_row) * OUT_W * FNUM + int'(issue_col) * FNUM + int'(issue_filter);
        chk("issue_pos", 32'(flat), 32'(issue_idx));
        p.due = cyc + lat;
        p.idx = issue_idx;
        pend.push_back(p);
        issue_idx++;
      end
      res_valid = 1'b0;
      if (!hold_res && pend.size() != 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        d = job_data(p.idx);
        res_valid = 1'b1;
        res_data  = d;
        e.addr = p.idx;
        e.data = (relu_cur && d[31]) ? 32'd0 : d;
        expq.push_back(e);
      end else if (spur_req) begin
        res_valid = 1'b1;
        res_data  = 32'h1234_5678;
        spur_req  = 1'b0;
      end
    end
  end

  task automatic start_layer(input bit relu, input int l);
    @(posedge clk); #2;
    lat         = l;
    relu_cur    = relu;
    relu_en     = relu;
    issue_idx   = 0;
    wr_count    = 0;
    done_base   = done_cnt;
    issue_ready = 1'b1;
    start       = 1'b1;
    @(posedge clk); #2;
    start   = 1'b0;
    relu_en = 1'b0;
  endtask

  task automatic finish_layer(input string tag);
    for (int i = 0; i < 3000 && done_cnt == done_base; i++) @(posedge clk);
    chk({tag, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
    chk({tag, "_done_after_wr"}, 32'(done_cyc - last_wr_cyc), 32'd1);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'(TOTAL));
    @(negedge clk);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int base;
    rst_n       = 1'b0;
    start       = 1'b0;
    relu_en     = 1'b0;
    issue_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Plain layer, 4-cycle engine.
    start_layer(1'b0, 4);
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
    finish_layer("basic");

    // Results withheld: eight jobs fill the engine, then the payload must hold.
    hold_res = 1'b1;
    start_layer(1'b0, 4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_issued", 32'(issue_idx), 32'd8);
    chk("full_valid", 32'(issue_valid), 32'd0);
    @(posedge clk); #2;
    issue_ready = 1'b0;
    hold_res    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (25) @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 32'(issue_valid), 32'd1);
      chk("stall_row", 32'(issue_row), 32'd0);
      chk("stall_col", 32'(issue_col), 32'd2);
      chk("stall_filter", 32'(issue_filter), 32'd0);
      chk("stall_issued", 32'(issue_idx), 32'd8);
    end
    @(posedge clk); #2 issue_ready = 1'b1;
    finish_layer("stall");

    // ReLU on sign bit, including negative zero.
    start_layer(1'b1, 4);
    finish_layer("relu");
    chk("relu_neg2", first_wr[0], 32'h0000_0000);
    chk("relu_pos1", first_wr[1], 32'h3F80_0000);
    chk("relu_negzero", first_wr[2], 32'h0000_0000);

    // Seven in flight: an issue and a result land every cycle.
    start_layer(1'b0, 7);
    repeat (40) @(posedge clk);
    base = issue_idx;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("steady_valid", 32'(issue_valid), 32'd1);
    end
    @(posedge clk);
    chk("steady_rate", 32'(issue_idx - base), 32'd4);
    finish_layer("steady");

    // Abort at write 60, then a clean layer.
    start_layer(1'b0, 4);
    for (int i = 0; i < 1000 && wr_count < 60; i++) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_wr_count", 32'(wr_count), 32'd60);
    chk("abort_no_done", 32'(done_cnt - done_base), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("abort_quiet", 32'(done_cnt - done_base), 32'd0);
    start_layer(1'b0, 4);
    finish_layer("after_abort");

    // Spurious result while idle.
    @(posedge clk); #2 spur_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("spur_err", 32'(err), 32'd1);
    chk("spur_wr_en", 32'(wr_en), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    start_layer(1'b0, 4);
    @(negedge clk);
    chk("spur_err_cleared", 32'(err), 32'd0);
    finish_layer("after_spur");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
